trinity_seq_ctrl: RTL and testbench
===================================

TRINITY_SEQ_CTRL -- requirements
Module: trinity_seq_ctrl

Interface
REQ-001 Parameter PRESCALE_W, default 8: width of the tick-divider register and of SET_DIV argument use.
REQ-002 Parameter STOP_ON_MATCH, default 0: 1 = RUN returns to IDLE on compare match.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 ena  input  1  tile enable; low freezes all state.
REQ-006 cmd_valid  input  1  command present.
REQ-007 cmd_op  input  3  opcode: 0 NOP, 1 RUN, 2 STOP, 3 STEP, 4 LOAD, 5 SET_DIV, 6 SET_CMP, 7 SET_DIR.
REQ-008 cmd_arg  input  8  command argument.
REQ-009 cmd_ready  output  1  controller can accept a command this cycle.
REQ-010 cnt_val  input  8  current value of the tile counter.
REQ-011 cnt_en  output  1  one-cycle count pulse to the counter.
REQ-012 cnt_up  output  1  count direction, 1 = increment.
REQ-013 cnt_load  output  1  one-cycle load strobe to the counter.
REQ-014 cnt_load_val  output  8  value loaded when cnt_load is high.
REQ-015 match  output  1  registered flag: cnt_val equals compare register.
REQ-016 state  output  2  encoded FSM state for debug: 0 IDLE, 1 RUN, 2 STEP, 3 LOAD.

Function
REQ-017 Command accepted only when cmd_valid, cmd_ready and ena are all high in the same cycle.
REQ-018 cmd_ready SHALL be high in IDLE and RUN with ena high; low in STEP, LOAD, or when ena low.
REQ-019 IDLE: RUN -> RUN (prescaler cleared); STEP -> STEP; LOAD -> LOAD (arg captured into cnt_load_val); STOP/NOP -> IDLE.
REQ-020 RUN: STOP -> IDLE; STEP ignored (stay RUN); LOAD -> LOAD then back to RUN; RUN re-clears prescaler.
REQ-021 STEP: cnt_en high exactly one cycle, then IDLE; STEP state lasts one cycle.
REQ-022 LOAD: cnt_load high exactly one cycle, then returns to the state it was entered from (IDLE or RUN); no cnt_en during LOAD.
REQ-023 SET_DIV, SET_CMP, SET_DIR update divider, compare register, cnt_up (arg[0]) without changing state; accepted in IDLE and RUN.
REQ-024 In RUN, prescaler counts 0..div; cnt_en pulses on the cycle prescaler equals div, prescaler then wraps to 0; div=0 -> cnt_en every RUN cycle.
REQ-025 SET_DIV in RUN clears prescaler; new divisor applies from next cycle.
REQ-026 STOP accepted in a cycle that would tick: STOP wins, no cnt_en that cycle.
REQ-027 match SHALL equal (cnt_val == cmp) registered, one-cycle latency, evaluated every enabled cycle in all states.
REQ-028 STOP_ON_MATCH=1: in RUN, match high forces IDLE next cycle, unless a LOAD is accepted that same cycle (LOAD wins).
REQ-029 ena low: FSM, prescaler, registers hold; cnt_en and cnt_load forced low.
REQ-030 cnt_up change takes effect on the next cnt_en pulse.

Reset
REQ-031 Async reset SHALL force: state IDLE, prescaler 0, div 0, cmp 8'hFF, cnt_up 1, cnt_load_val 0, cnt_en 0, cnt_load 0, match 0.
REQ-032 Reset mid-RUN/STEP/LOAD SHALL abort immediately; no pulse emitted after rst_n deasserts until a new command.
REQ-033 cmd_ready low while rst_n low; high on first enabled cycle after release.

Structure
REQ-034 Opcode constants and state encoding SHALL live in shared package trinity_pkg.
REQ-035 Prescaler SHALL be sub-module trinity_prescaler (clear, enable, div in; tick out).
REQ-036 All outputs registered; no combinational path from cmd_* to cnt_*.

Verification
REQ-037 Reset, RUN with div=0 for 10 cycles -> 10 consecutive cnt_en pulses, cnt_up=1.
REQ-038 SET_DIV 3, RUN -> cnt_en every 4th cycle; STOP on a tick cycle -> no pulse, state IDLE.
REQ-039 LOAD 0x5A while in RUN -> cnt_load one cycle with cnt_load_val 0x5A, cnt_en absent that cycle, state back to RUN.
REQ-040 SET_CMP 0x10, STOP_ON_MATCH=1, cnt_val driven to 0x10 -> match high next cycle, state IDLE the cycle after.
REQ-041 STEP from IDLE with ena dropped mid-sequence -> single cnt_en after ena returns, cmd_ready low throughout STEP.
REQ-042 rst_n asserted during RUN with div=5 -> all outputs at reset values asynchronously, no cnt_en after release.

Source files
------------

// File: rtl/trinity_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trinity_pkg                                                              |
// | Opcode and FSM state encodings shared by the trinity sequencer.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package trinity_pkg;

    localparam logic [2:0] C_OP_NOP     = 3'd0;
    localparam logic [2:0] C_OP_RUN     = 3'd1;
    localparam logic [2:0] C_OP_STOP    = 3'd2;
    localparam logic [2:0] C_OP_STEP    = 3'd3;
    localparam logic [2:0] C_OP_LOAD    = 3'd4;
    localparam logic [2:0] C_OP_SET_DIV = 3'd5;
    localparam logic [2:0] C_OP_SET_CMP = 3'd6;
    localparam logic [2:0] C_OP_SET_DIR = 3'd7;

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_RUN  = 2'd1;
    localparam logic [1:0] C_ST_STEP = 2'd2;
    localparam logic [1:0] C_ST_LOAD = 2'd3;

endpackage
`default_nettype wire

// File: rtl/trinity_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trinity_prescaler                                                        |
// | Counts 0..div while enabled; tick is high on the cycle count == div.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module trinity_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] r_cnt;

    assign tick = (r_cnt == div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= tick ? '0 : r_cnt + PRESCALE_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/trinity_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trinity_seq_ctrl                                                         |
// | Command-driven sequencer producing count/load strobes for a tile counter.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module trinity_seq_ctrl
    import trinity_pkg::*;
#(
    parameter int PRESCALE_W    = 8,
    parameter bit STOP_ON_MATCH = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_arg,
    output logic       cmd_ready,
    input  logic [7:0] cnt_val,
    output logic       cnt_en,
    output logic       cnt_up,
    output logic       cnt_load,
    output logic [7:0] cnt_load_val,
    output logic       match,
    output logic [1:0] state
);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_ret_run;
    logic [PRESCALE_W-1:0] r_div;
    logic [PRESCALE_W-1:0] w_div_arg;
    logic [7:0]            r_cmp;
    logic [7:0]            r_load_val;
    logic                  r_cnt_up;
    logic                  r_cnt_en;
    logic                  r_cnt_load;
    logic                  r_match;
    logic                  w_en_nxt;
    logic                  w_load_nxt;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_tick;
    logic                  w_presc_clr;
    logic                  w_presc_en;

    generate
        if (PRESCALE_W >= 8) begin : g_div_wide
            assign w_div_arg = PRESCALE_W'(cmd_arg);
        end else begin : g_div_narrow
            assign w_div_arg = cmd_arg[PRESCALE_W-1:0];
        end
    endgenerate

    assign w_ready  = rst_n && ena && ((r_state == C_ST_IDLE) || (r_state == C_ST_RUN));
    assign w_accept = cmd_valid && w_ready;

    assign w_presc_clr = w_accept && ((cmd_op == C_OP_RUN) || (cmd_op == C_OP_SET_DIV));
    assign w_presc_en  = ena && (r_state == C_ST_RUN);

    trinity_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_presc_clr),
        .enable (w_presc_en),
        .div    (r_div),
        .tick   (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_ST_IDLE;
        end else if (ena) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ST_IDLE: begin
                if (w_accept) begin
                    case (cmd_op)
                        C_OP_RUN:  w_state_nxt = C_ST_RUN;
                        C_OP_STEP: w_state_nxt = C_ST_STEP;
                        C_OP_LOAD: w_state_nxt = C_ST_LOAD;
                        C_OP_NOP, C_OP_STOP, C_OP_SET_DIV, C_OP_SET_CMP, C_OP_SET_DIR:
                                   w_state_nxt = C_ST_IDLE;
                    endcase
                end
            end
            C_ST_RUN: begin
                // A LOAD beats both STOP and the compare-match auto-stop.
                if (w_accept && (cmd_op == C_OP_LOAD)) begin
                    w_state_nxt = C_ST_LOAD;
                end else if (w_accept && (cmd_op == C_OP_STOP)) begin
                    w_state_nxt = C_ST_IDLE;
                end else if (STOP_ON_MATCH && r_match) begin
                    w_state_nxt = C_ST_IDLE;
                end
            end
            C_ST_STEP: w_state_nxt = C_ST_IDLE;
            C_ST_LOAD: w_state_nxt = r_ret_run ? C_ST_RUN : C_ST_IDLE;
        endcase
    end

    // Strobes are registered: a RUN tick shows on cnt_en the cycle after the
    // prescaler reaches div, and is dropped if RUN is being left that cycle.
    always_comb begin
        w_en_nxt   = 1'b0;
        w_load_nxt = 1'b0;
        case (r_state)
            C_ST_IDLE: begin
                w_en_nxt   = w_accept && (cmd_op == C_OP_STEP);
                w_load_nxt = w_accept && (cmd_op == C_OP_LOAD);
            end
            C_ST_RUN: begin
                w_en_nxt   = w_tick && (w_state_nxt == C_ST_RUN);
                w_load_nxt = w_accept && (cmd_op == C_OP_LOAD);
            end
            default: begin
                w_en_nxt   = 1'b0;
                w_load_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_en   <= 1'b0;
            r_cnt_load <= 1'b0;
            r_match    <= 1'b0;
            r_ret_run  <= 1'b0;
            r_div      <= '0;
            r_cmp      <= 8'hFF;
            r_cnt_up   <= 1'b1;
            r_load_val <= 8'h00;
        end else if (ena) begin
            r_cnt_en   <= w_en_nxt;
            r_cnt_load <= w_load_nxt;
            r_match    <= (cnt_val == r_cmp);
            if (w_accept) begin
                case (cmd_op)
                    C_OP_LOAD: begin
                        r_load_val <= cmd_arg;
                        r_ret_run  <= (r_state == C_ST_RUN);
                    end
                    C_OP_SET_DIV: r_div    <= w_div_arg;
                    C_OP_SET_CMP: r_cmp    <= cmd_arg;
                    C_OP_SET_DIR: r_cnt_up <= cmd_arg[0];
                    default: ;
                endcase
            end
        end
    end

    assign cmd_ready    = w_ready;
    assign cnt_en       = r_cnt_en && ena;
    assign cnt_load     = r_cnt_load && ena;
    assign cnt_up       = r_cnt_up;
    assign cnt_load_val = r_load_val;
    assign match        = r_match;
    assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_trinity_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_trinity_seq_ctrl                                                      |
// | Directed vector table plus hand-written corner sequences.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_trinity_seq_ctrl;
    import trinity_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic [7:0] cmd_arg;
    logic       cmd_ready;
    logic [7:0] cnt_val;
    logic       cnt_en;
    logic       cnt_up;
    logic       cnt_load;
    logic [7:0] cnt_load_val;
    logic       match;
    logic [1:0] state;

    int n_pass = 0;
    int n_tot  = 0;
    int pulses = 0;
    bit mon_on = 1'b0;

    always #5 clk = ~clk;

    trinity_seq_ctrl #(
        .PRESCALE_W    (8),
        .STOP_ON_MATCH (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .cmd_valid    (cmd_valid),
        .cmd_op       (cmd_op),
        .cmd_arg      (cmd_arg),
        .cmd_ready    (cmd_ready),
        .cnt_val      (cnt_val),
        .cnt_en       (cnt_en),
        .cnt_up       (cnt_up),
        .cnt_load     (cnt_load),
        .cnt_load_val (cnt_load_val),
        .match        (match),
        .state        (state)
    );

    // The counter only sees pulses on enabled edges.
    always @(negedge clk) begin
        if (mon_on && cnt_en && ena) pulses++;
    end

    typedef struct {
        logic       valid;
        logic [2:0] op;
        logic [7:0] arg;
        logic       en_in;
        logic [1:0] st;
        logic       en;
        logic       ld;
        logic [7:0] lval;
        logic       rdy;
        logic       up;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [2:0] op, input logic [7:0] arg,
                                input logic e, input logic [1:0] st, input logic en,
                                input logic ld, input logic [7:0] lval, input logic rdy,
                                input logic up);
        vec_t r;
        r.valid = v;  r.op = op;  r.arg = arg;  r.en_in = e;
        r.st = st;    r.en = en;  r.ld = ld;    r.lval = lval;
        r.rdy = rdy;  r.up = up;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        step();
        cmd_valid = 1'b0;
        cmd_op    = C_OP_NOP;
        cmd_arg   = 8'h00;
    endtask

    task automatic chk_core(input string tag, input logic [1:0] st, input logic en,
                            input logic ld, input logic rdy);
        chk({tag, "_state"}, 32'(state), 32'(st));
        chk({tag, "_cnt_en"}, 32'(cnt_en), 32'(en));
        chk({tag, "_cnt_load"}, 32'(cnt_load), 32'(ld));
        chk({tag, "_ready"}, 32'(cmd_ready), 32'(rdy));
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; cmd_valid = 1'b0; cmd_op = C_OP_NOP;
        cmd_arg = 8'h00; cnt_val = 8'h00;

        // Reset values
        #12;
        chk_core("rst", C_ST_IDLE, 1'b0, 1'b0, 1'b0);
        chk("rst_up", 32'(cnt_up), 32'd1);
        chk("rst_lval", 32'(cnt_load_val), 32'h00);
        chk("rst_match", 32'(match), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 32'(cmd_ready), 32'd1);
        step();

        // RUN with div=0: one pulse every cycle after one cycle of latency
        send(C_OP_RUN, 8'h00);
        chk_core("run0_entry", C_ST_RUN, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("run0_pulse%0d", i), 32'(cnt_en), 32'd1);
            chk($sformatf("run0_up%0d", i), 32'(cnt_up), 32'd1);
        end
        send(C_OP_STOP, 8'h00);
        chk_core("run0_stop", C_ST_IDLE, 1'b0, 1'b0, 1'b1);

        // Table: direction, div=3 ticks, STEP ignored in RUN, STOP on tick,
        // LOAD/STEP from IDLE, command blocked by ena low
        tbl.push_back(mk(1, C_OP_SET_DIR, 8'h00, 1, C_ST_IDLE, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(1, C_OP_SET_DIR, 8'h01, 1, C_ST_IDLE, 0, 0, 8'h00, 1, 1));
        tbl.push_back(mk(1, C_OP_SET_DIV, 8'h03, 1, C_ST_IDLE, 0, 0, 8'h00, 1, 1));
        tbl.push_back(mk(1, C_OP_RUN,     8'h00, 1, C_ST_RUN,  0, 0, 8'h00, 1, 1));
        tbl.push_back(mk(0, C_OP_NOP,     8'h00, 1, C_ST_RUN,  0, 0, 8'h00, 1, 1));
        tbl.push_back(mk(0, C_OP_NOP,     8'h00, 1, C_ST_RUN,  0, 0, 8'h00, 1, 1));
        tbl.push_back(mk(0, C_OP_NOP,     8'h00, 1, C_ST_RUN,  0, 0, 8'h00, 1, 1));
        tbl.push_back(mk(0, C_OP_NOP,     8'h00, 1, C_ST_RUN,  1, 0, 8'h00, 1, 1));
        tbl.push_back(mk(0, C_OP_NOP,     8'h00, 1, C_ST_RUN,  0, 0, 8'h00, 1, 1));
        tbl.push_back(mk(1, C_OP_STEP,    8'h00, 1, C_ST_RUN,  0, 0, 8'h00, 1, 1));
        tbl.push_back(mk(0, C_OP_NOP,     8'h00, 1, C_ST_RUN,  0, 0, 8'h00, 1, 1));
        tbl.push_back(mk(0, C_OP_NOP,     8'h00, 1, C_ST_RUN,  1, 0, 8'h00, 1, 1));
        tbl.push_back(mk(0, C_OP_NOP,     8'h00, 1, C_ST_RUN,  0, 0, 8'h00, 1, 1));
        tbl.push_back(mk(0, C_OP_NOP,     8'h00, 1, C_ST_RUN,  0, 0, 8'h00, 1, 1));
        tbl.push_back(mk(0, C_OP_NOP,     8'h00, 1, C_ST_RUN,  0, 0, 8'h00, 1, 1));
        tbl.push_back(mk(1, C_OP_STOP,    8'h00, 1, C_ST_IDLE, 0, 0, 8'h00, 1, 1));
        tbl.push_back(mk(1, C_OP_LOAD,    8'h33, 1, C_ST_LOAD, 0, 1, 8'h33, 0, 1));
        tbl.push_back(mk(0, C_OP_NOP,     8'h00, 1, C_ST_IDLE, 0, 0, 8'h33, 1, 1));
        tbl.push_back(mk(1, C_OP_STEP,    8'h00, 1, C_ST_STEP, 1, 0, 8'h33, 0, 1));
        tbl.push_back(mk(0, C_OP_NOP,     8'h00, 1, C_ST_IDLE, 0, 0, 8'h33, 1, 1));
        tbl.push_back(mk(1, C_OP_RUN,     8'h00, 0, C_ST_IDLE, 0, 0, 8'h33, 0, 1));
        tbl.push_back(mk(0, C_OP_NOP,     8'h00, 1, C_ST_IDLE, 0, 0, 8'h33, 1, 1));
        for (int i = 0; i < tbl.size(); i++) begin
            cmd_valid = tbl[i].valid;
            cmd_op    = tbl[i].op;
            cmd_arg   = tbl[i].arg;
            ena       = tbl[i].en_in;
            step();
            chk_core($sformatf("row%0d", i), tbl[i].st, tbl[i].en, tbl[i].ld, tbl[i].rdy);
            chk($sformatf("row%0d_lval", i), 32'(cnt_load_val), 32'(tbl[i].lval));
            chk($sformatf("row%0d_up", i), 32'(cnt_up), 32'(tbl[i].up));
        end
        cmd_valid = 1'b0; cmd_op = C_OP_NOP; cmd_arg = 8'h00; ena = 1'b1;

        // LOAD while running: strobe with no count, then back to RUN
        send(C_OP_SET_DIV, 8'h00);
        send(C_OP_RUN, 8'h00);
        step();
        send(C_OP_LOAD, 8'h5A);
        chk_core("ldrun_load", C_ST_LOAD, 1'b0, 1'b1, 1'b0);
        chk("ldrun_lval", 32'(cnt_load_val), 32'h5A);
        step();
        chk_core("ldrun_back", C_ST_RUN, 1'b0, 1'b0, 1'b1);
        step();
        chk("ldrun_resume", 32'(cnt_en), 32'd1);
        send(C_OP_STOP, 8'h00);

        // STEP with ena dropped: exactly one effective pulse, never ready
        mon_on = 1'b1; pulses = 0;
        send(C_OP_STEP, 8'h00);
        ena = 1'b0;
        #1;
        chk_core("stepena_off", C_ST_STEP, 1'b0, 1'b0, 1'b0);
        step(); step();
        chk_core("stepena_hold", C_ST_STEP, 1'b0, 1'b0, 1'b0);
        ena = 1'b1;
        #1;
        chk_core("stepena_on", C_ST_STEP, 1'b1, 1'b0, 1'b0);
        step();
        chk_core("stepena_done", C_ST_IDLE, 1'b0, 1'b0, 1'b1);
        step();
        mon_on = 1'b0;
        chk("stepena_pulses", 32'(pulses), 32'd1);

        // Compare match stops RUN; LOAD wins over the auto-stop
        send(C_OP_SET_CMP, 8'h10);
        chk("cmp_nomatch", 32'(match), 32'd0);
        send(C_OP_RUN, 8'h00);
        cnt_val = 8'h10;
        step();
        chk("cmp_match", 32'(match), 32'd1);
        chk("cmp_still_run", 32'(state), 32'(C_ST_RUN));
        step();
        chk_core("cmp_stopped", C_ST_IDLE, 1'b0, 1'b0, 1'b1);
        send(C_OP_RUN, 8'h00);
        chk("cmpld_run", 32'(state), 32'(C_ST_RUN));
        send(C_OP_LOAD, 8'h21);
        chk("cmpld_load", 32'(state), 32'(C_ST_LOAD));
        step();
        chk("cmpld_ret", 32'(state), 32'(C_ST_RUN));
        step();
        chk("cmpld_stop", 32'(state), 32'(C_ST_IDLE));
        cnt_val = 8'h00;
        step();
        chk("cmp_clear", 32'(match), 32'd0);

        // Asynchronous reset in RUN with div=5
        send(C_OP_SET_DIR, 8'h00);
        send(C_OP_SET_DIV, 8'h05);
        send(C_OP_RUN, 8'h00);
        step(); step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        chk_core("arst", C_ST_IDLE, 1'b0, 1'b0, 1'b0);
        chk("arst_up", 32'(cnt_up), 32'd1);
        chk("arst_lval", 32'(cnt_load_val), 32'h00);
        chk("arst_match", 32'(match), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_on = 1'b1; pulses = 0;
        #1;
        chk("arst_rel_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 12; i++) step();
        mon_on = 1'b0;
        chk("arst_no_pulse", 32'(pulses), 32'd0);
        chk("arst_idle", 32'(state), 32'(C_ST_IDLE));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
